// File: rtl/wb_to_vmemem_pkg.sv
// -----------------------------------------------------------------------------
// wb_to_vmemem_pkg
// Shared definitions for the Wishbone-to-VME-memory bridge:
//   state_t : bridge FSM states (IDLE / ISSUE / WAIT)
//   DATA_W  : data path width of both the Wishbone and memory sides
//   clog2   : ceiling log2, used to size the Done timeout counter
// -----------------------------------------------------------------------------
package wb_to_vmemem_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Ceiling log2; clog2(1) = 0, clog2(2) = 1, clog2(256) = 8.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_to_vmemem_timeout_ctr.sv
// -----------------------------------------------------------------------------
// vmemem_timeout_ctr
// Saturating cycle counter used by the bridge to give up on a missing Done.
// Only instantiated when WB_TO_VMEMEM_TIMEOUT_EN is defined.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   i_clear    in   force the counter to 0
//   i_enable   in   count one cycle (saturates at TIMEOUT)
//   o_expired  out  the counter reaches (or sits at) TIMEOUT on this edge
// -----------------------------------------------------------------------------
module vmemem_timeout_ctr
    import wb_to_vmemem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != CNT_W'(TIMEOUT))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Look-ahead: flagging one count early lets the FSM act on the same edge
    // at which the counter would become TIMEOUT.
    assign o_expired = i_enable && (r_cnt >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_to_vmemem_bridge.sv
// -----------------------------------------------------------------------------
// wb_to_vmemem_bridge
// Pipelined Wishbone B4 slave that turns each accepted request into a single
// one-cycle RdMem/WrMem strobe on a VME-style register-block memory port, waits
// for the matching Done and answers Wishbone with ack (or err on timeout).
// One transaction outstanding; Wishbone is stalled while busy.
//
// Optional feature macro: WB_TO_VMEMEM_TIMEOUT_EN
//   defined   : give up after TIMEOUT cycles without Done, return wb err
//   undefined : wait for Done indefinitely, o_wb_err tied low
//
// Ports:
//   clk, rst_n          clock / synchronous active-low reset
//   i_wb_cyc/stb/we     Wishbone cycle, strobe, write enable
//   i_wb_adr            byte address (word address = i_wb_adr[ADDR_W-1:2])
//   i_wb_sel            byte selects (not forwarded; always full-word)
//   i_wb_dat/o_wb_dat   write / read data
//   o_wb_ack/o_wb_err   one-cycle completion / error
//   o_wb_stall          not ready for a new request
//   o_mem_addr          word address, held from issue until next accept
//   o_mem_wr_data       write data, held like o_mem_addr
//   o_mem_rd/o_mem_wr   one-cycle read / write strobes
//   i_mem_rd_data       read data, valid with i_mem_rd_done
//   i_mem_rd_done/i_mem_wr_done  completion from the memory side
// -----------------------------------------------------------------------------
module wb_to_vmemem_bridge
    import wb_to_vmemem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    input  logic              i_wb_we,
    input  logic [ADDR_W-1:0] i_wb_adr,
    input  logic [3:0]        i_wb_sel,
    input  logic [DATA_W-1:0] i_wb_dat,
    output logic [DATA_W-1:0] o_wb_dat,
    output logic              o_wb_ack,
    output logic              o_wb_err,
    output logic              o_wb_stall,
    output logic [ADDR_W-3:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wr_data,
    output logic              o_mem_rd,
    output logic              o_mem_wr,
    input  logic [DATA_W-1:0] i_mem_rd_data,
    input  logic              i_mem_rd_done,
    input  logic              i_mem_wr_done
);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_we;
    logic [ADDR_W-3:0] r_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_abort;
    logic              r_ack;
    logic              r_err;

    logic              w_accept;
    logic              w_done;
    logic              w_expired;
    logic              w_aborted;
    logic              w_complete;
    logic              w_timeout;

    // No accept while ack/err is on the bus: the stall covers that cycle too.
    assign w_accept  = (r_state == IDLE) && i_wb_cyc && i_wb_stb && !r_ack && !r_err;

    // Only the Done matching the issued direction completes the transaction.
    assign w_done    = r_we ? i_mem_wr_done : i_mem_rd_done;

    // Dropping cyc on the completing cycle itself also suppresses the response.
    assign w_aborted = r_abort || !i_wb_cyc;

    always_comb begin
        w_state_next = r_state;
        w_complete   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                // Zero-latency slave: Done alongside the strobe completes now.
                if (w_done) begin
                    w_complete   = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                // Done wins over a timeout expiring on the same edge.
                if (w_done) begin
                    w_complete   = 1'b1;
                    w_state_next = IDLE;
                end else if (w_expired) begin
                    w_timeout    = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wr_data <= '0;
            r_rd_data <= '0;
            r_abort   <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ack   <= w_complete && !w_aborted;

            if (w_accept) begin
                r_we      <= i_wb_we;
                r_addr    <= i_wb_adr[ADDR_W-1:2];
                r_wr_data <= i_wb_dat;
            end

            if (w_complete && !w_aborted && !r_we) begin
                r_rd_data <= i_mem_rd_data;
            end

            if (w_state_next == IDLE) begin
                r_abort <= 1'b0;
            end else if ((r_state != IDLE) && !i_wb_cyc) begin
                r_abort <= 1'b1;
            end
        end
    end

`ifdef WB_TO_VMEMEM_TIMEOUT_EN
    logic w_ctr_clear;
    logic w_ctr_enable;

    // Counting starts in the ISSUE cycle and restarts on every return to IDLE.
    assign w_ctr_clear  = (r_state == IDLE);
    assign w_ctr_enable = (r_state != IDLE);

    vmemem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_ctr_clear),
        .i_enable  (w_ctr_enable),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout && !w_aborted;
        end
    end

    logic w_unused;
    assign w_unused = ^{i_wb_sel, i_wb_adr[1:0]};
`else
    assign w_expired = 1'b0;
    assign r_err     = 1'b0;

    logic w_unused;
    assign w_unused = ^{i_wb_sel, i_wb_adr[1:0], w_timeout, 16'(TIMEOUT)};
`endif

    assign o_wb_dat      = r_rd_data;
    assign o_wb_ack      = r_ack;
    assign o_wb_err      = r_err;
    assign o_wb_stall    = (r_state != IDLE) || r_ack || r_err;
    assign o_mem_addr    = r_addr;
    assign o_mem_wr_data = r_wr_data;
    assign o_mem_rd      = (r_state == ISSUE) && !r_we;
    assign o_mem_wr      = (r_state == ISSUE) && r_we;

endmodule
